// File: rtl/cis_sequencer.sv
// CMOS image sensor row sequencer: plays per-phase signal patterns on a divided
// tick through CCD reset, integration and skip/readout passes, row by row.
module cis_sequencer #(
    parameter  int NUM_SIGNALS = 9,
    parameter  int PATTERN_LEN = 16,
    parameter  int MAX_ROWS    = 16,
    parameter  int SKIP_W      = 14,
    parameter  int DIV_W       = 10,
    localparam int LEN_W       = $clog2(PATTERN_LEN + 1),
    localparam int STEP_W      = $clog2(PATTERN_LEN),
    localparam int NROW_W      = $clog2(MAX_ROWS + 1),
    localparam int ROW_W       = $clog2(MAX_ROWS)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [DIV_W-1:0]                       clk_div,
    input  logic                                   integration,
    input  logic                                   abort,
    input  logic                                   global_shutter,
    input  logic [NROW_W-1:0]                      num_rows,
    input  logic [SKIP_W-1:0]                      skip_samples,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pat_reset,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pat_integ,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pat_skip,
    input  logic [LEN_W-1:0]                       len_reset,
    input  logic [LEN_W-1:0]                       len_integ,
    input  logic [LEN_W-1:0]                       len_skip,
    output logic [NUM_SIGNALS-1:0]                 sig_out,
    output logic                                   cis_RowRst,
    output logic                                   cis_RowClk,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic [1:0]                             phase,
    output logic [ROW_W-1:0]                       row_idx,
    output logic [SKIP_W-1:0]                      skip_idx
);

    typedef enum logic [1:0] {IDLE, CCD_RESET, INTEGRATION, SKIPPING} state_t;
    typedef logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pat_t;

    // Lengths and row count are stored already clamped, as last-index values.
    typedef struct packed {
        logic              gs;
        logic [ROW_W-1:0]  last_row;
        logic [SKIP_W-1:0] skips;
        logic [STEP_W-1:0] last_r;
        logic [STEP_W-1:0] last_i;
        logic [STEP_W-1:0] last_s;
    } cfg_t;

    function automatic logic [STEP_W-1:0] last_step(input logic [LEN_W-1:0] l);
        if (l == '0 || 32'(l) > PATTERN_LEN) return STEP_W'(PATTERN_LEN - 1);
        return STEP_W'(l - 1'b1);
    endfunction

    function automatic logic [ROW_W-1:0] last_row_of(input logic [NROW_W-1:0] n);
        if (n == '0) return '0;
        if (32'(n) > MAX_ROWS) return ROW_W'(MAX_ROWS - 1);
        return ROW_W'(n - 1'b1);
    endfunction

    logic [DIV_W-1:0]       div_q;
    logic                   tick;
    state_t                 state_q, state_n;
    logic [STEP_W-1:0]      step_q, step_n;
    logic [ROW_W-1:0]       row_q, row_n;
    logic [SKIP_W-1:0]      skip_q, skip_n;
    logic                   end_row, end_frame;
    cfg_t                   cfg_in, cfg_q, cfg;
    pat_t                   pr_q, pi_q, ps_q, pr, pi, ps, pat_sel;
    logic [NUM_SIGNALS-1:0] sig_q, sig_n;
    logic                   row_clk_q, row_rst_q, done_q;

    // >= rather than == so a shrinking clk_div cannot strand the counter above it.
    assign tick = (div_q >= clk_div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        cfg_in.gs       = global_shutter;
        cfg_in.last_row = last_row_of(num_rows);
        cfg_in.skips    = skip_samples;
        cfg_in.last_r   = last_step(len_reset);
        cfg_in.last_i   = last_step(len_integ);
        cfg_in.last_s   = last_step(len_skip);
    end

    // Snapshot tracks the inputs while idle and freezes once a frame starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q <= '0;
            pr_q  <= '0;
            pi_q  <= '0;
            ps_q  <= '0;
        end else if (state_q == IDLE) begin
            cfg_q <= cfg_in;
            pr_q  <= pat_reset;
            pi_q  <= pat_integ;
            ps_q  <= pat_skip;
        end
    end

    assign cfg = (state_q == IDLE) ? cfg_in    : cfg_q;
    assign pr  = (state_q == IDLE) ? pat_reset : pr_q;
    assign pi  = (state_q == IDLE) ? pat_integ : pi_q;
    assign ps  = (state_q == IDLE) ? pat_skip  : ps_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            row_q   <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_n;
            step_q  <= step_n;
            row_q   <= row_n;
            skip_q  <= skip_n;
        end
    end

    // Next state
    always_comb begin
        state_n   = state_q;
        step_n    = step_q;
        row_n     = row_q;
        skip_n    = skip_q;
        end_row   = 1'b0;
        end_frame = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: if (integration) begin
                    state_n = CCD_RESET;
                    step_n  = '0;
                    row_n   = '0;
                    skip_n  = '0;
                end
                CCD_RESET: begin
                    if (step_q == cfg.last_r) begin
                        state_n = INTEGRATION;
                        step_n  = '0;
                    end else step_n = step_q + 1'b1;
                end
                INTEGRATION: if (!integration) begin
                    if (step_q == cfg.last_i) begin
                        state_n = SKIPPING;
                        step_n  = '0;
                        skip_n  = '0;
                    end else step_n = step_q + 1'b1;
                end
                SKIPPING: begin
                    if (step_q == cfg.last_s) begin
                        step_n = '0;
                        if (skip_q < cfg.skips) skip_n = skip_q + 1'b1;
                        else begin
                            end_row = 1'b1;
                            skip_n  = '0;
                            if (cfg.gs && row_q < cfg.last_row) row_n = row_q + 1'b1;
                            else begin
                                end_frame = 1'b1;
                                state_n   = IDLE;
                                row_n     = '0;
                            end
                        end
                    end else step_n = step_q + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        if (abort) begin
            state_n   = IDLE;
            step_n    = '0;
            row_n     = '0;
            skip_n    = '0;
            end_row   = 1'b0;
            end_frame = 1'b0;
        end
    end

    // Pattern lookup is done on the next state so sig_out lines up with phase/step.
    always_comb begin
        case (state_n)
            CCD_RESET:   pat_sel = pr;
            INTEGRATION: pat_sel = pi;
            SKIPPING:    pat_sel = ps;
            default:     pat_sel = '0;
        endcase
        sig_n = '0;
        for (int k = 0; k < NUM_SIGNALS; k++)
            sig_n[k] = pat_sel[k][STEP_W'(PATTERN_LEN - 1) - step_n];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q     <= '0;
            row_clk_q <= 1'b0;
            row_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            sig_q  <= sig_n;
            done_q <= end_frame;
            if (abort) begin
                row_clk_q <= 1'b0;
                row_rst_q <= 1'b1;
            end else if (tick) begin
                row_clk_q <= end_row;
                row_rst_q <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        busy       = (state_q != IDLE);
        phase      = state_q;
        row_idx    = row_q;
        skip_idx   = skip_q;
        sig_out    = sig_q;
        cis_RowClk = row_clk_q;
        cis_RowRst = row_rst_q;
        frame_done = done_q;
    end

endmodule
